miso_tx_scheduler: RTL and testbench

Schedules outbound 64-bit data packets from the chip's event/config FIFO onto the four MISO UART transmitters. Each packet is fetched once and loaded into exactly one enabled, idle transmitter, chosen round-robin. Sits between the FIFO read port and the per-port `uart_tx` instances in `larpix_v2`. The MCP-side MISO lanes see packets interleaved across the enabled ports.

---
 rtl/miso_tx_scheduler.sv | 115 +++++++++++
 tb/tb_miso_tx_scheduler.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/miso_tx_scheduler.sv
// Round-robin scheduler that pops one packet at a time from the event/config
// FIFO and loads it into a single enabled, idle MISO UART transmitter.
module miso_tx_scheduler #(
    parameter int WIDTH    = 64,
    parameter int NUMPORTS = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUMPORTS-1:0] enable_miso,
    input  logic                fifo_empty,
    input  logic [WIDTH-1:0]    fifo_data,
    output logic                fifo_rd_en,
    input  logic [NUMPORTS-1:0] tx_busy,
    output logic [NUMPORTS-1:0] ld_tx_data,
    output logic [WIDTH-1:0]    tx_data,
    output logic [15:0]         tx_count
);

    localparam int PW = (NUMPORTS > 1) ? $clog2(NUMPORTS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_CAPTURE,
        S_LOAD
    } state_t;

    state_t                r_state;
    logic [PW-1:0]         r_last_port;
    logic [PW-1:0]         r_sel_port;
    logic                  r_just_loaded;
    logic                  r_fifo_rd_en;
    logic [NUMPORTS-1:0]   r_ld_tx_data;
    logic [WIDTH-1:0]      r_tx_data;
    logic [15:0]           r_tx_count;

    logic [NUMPORTS-1:0]   w_eligible;
    logic [PW-1:0]         w_idx;
    logic [PW-1:0]         w_sel;
    logic                  w_found;

    // The port loaded last cycle is masked until its tx_busy has had time to rise.
    always_comb begin
        w_eligible = '0;
        for (int p = 0; p < NUMPORTS; p++) begin
            w_eligible[p] = enable_miso[p] & ~tx_busy[p]
                          & ~(r_just_loaded & (r_last_port == PW'(p)));
        end
    end

    // NOTE: every combinational output gets a default before the loop so no latch is inferred.
    always_comb begin
        w_found = 1'b0;
        w_sel   = r_last_port;
        w_idx   = '0;
        for (int k = 1; k <= NUMPORTS; k++) begin
            w_idx = PW'((int'(r_last_port) + k) % NUMPORTS);
            if (!w_found && w_eligible[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments only, so every branch sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_last_port   <= PW'(NUMPORTS - 1);
            r_sel_port    <= '0;
            r_just_loaded <= 1'b0;
            r_fifo_rd_en  <= 1'b0;
            r_ld_tx_data  <= '0;
            r_tx_data     <= '0;
            r_tx_count    <= '0;
        end else begin
            // NOTE: strobes default low here so each is high for exactly one cycle.
            r_fifo_rd_en <= 1'b0;
            r_ld_tx_data <= '0;
            case (r_state)
                S_IDLE: begin
                    r_just_loaded <= 1'b0;
                    if (!fifo_empty && w_found) begin
                        r_sel_port   <= w_sel;
                        r_fifo_rd_en <= 1'b1;
                        r_state      <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    r_state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    r_tx_data    <= fifo_data;
                    r_ld_tx_data <= NUMPORTS'(1) << r_sel_port;
                    r_state      <= S_LOAD;
                end
                S_LOAD: begin
                    r_last_port   <= r_sel_port;
                    r_just_loaded <= 1'b1;
                    r_tx_count    <= r_tx_count + 16'd1;
                    r_state       <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign fifo_rd_en = r_fifo_rd_en;
    assign ld_tx_data = r_ld_tx_data;
    assign tx_data    = r_tx_data;
    assign tx_count   = r_tx_count;

endmodule

// File: tb/tb_miso_tx_scheduler.sv
// Directed self-checking bench for miso_tx_scheduler: reset, single load,
// round-robin order and spacing, busy skip, zero mask and reset mid-transaction.
module tb_miso_tx_scheduler;

    localparam int WIDTH    = 64;
    localparam int NUMPORTS = 4;

    logic                clk = 1'b0;
    logic                reset_n;
    logic [NUMPORTS-1:0] enable_miso;
    logic                fifo_empty;
    logic [WIDTH-1:0]    fifo_data;
    logic                fifo_rd_en;
    logic [NUMPORTS-1:0] tx_busy;
    logic [NUMPORTS-1:0] ld_tx_data;
    logic [WIDTH-1:0]    tx_data;
    logic [15:0]         tx_count;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // FIFO model: packets stored by push index, popped one per rd_en, data valid next cycle.
    logic [WIDTH-1:0] pkt_mem [0:63];
    int n_push = 0;
    int n_pop  = 0;

    assign fifo_empty = (n_push == n_pop);

    miso_tx_scheduler #(.WIDTH(WIDTH), .NUMPORTS(NUMPORTS)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable_miso (enable_miso),
        .fifo_empty  (fifo_empty),
        .fifo_data   (fifo_data),
        .fifo_rd_en  (fifo_rd_en),
        .tx_busy     (tx_busy),
        .ld_tx_data  (ld_tx_data),
        .tx_data     (tx_data),
        .tx_count    (tx_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_rd_en === 1'b1 && n_pop < n_push) begin
            fifo_data <= pkt_mem[n_pop];
            n_pop     <= n_pop + 1;
        end
    end

    // Strobe-shape monitor: one-hot load, and neither strobe high two cycles running.
    int   n_proto = 0;
    logic prev_rd = 1'b0;
    logic prev_ld = 1'b0;
    always @(negedge clk) begin
        if ($countones(ld_tx_data) > 1) n_proto++;
        if (fifo_rd_en === 1'b1 && prev_rd) n_proto++;
        if (ld_tx_data != '0 && prev_ld) n_proto++;
        prev_rd = (fifo_rd_en === 1'b1);
        prev_ld = (ld_tx_data != '0);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [WIDTH-1:0] d);
        pkt_mem[n_push] = d;
        n_push++;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    // Waits up to budget cycles for a load strobe; a timeout returns ld=0.
    task automatic wait_load(input int budget, output logic [NUMPORTS-1:0] ld,
                             output logic [WIDTH-1:0] d, output int at);
        bit found;
        found = 1'b0;
        ld = '0;
        d  = '0;
        at = -1;
        for (int i = 0; i < budget; i++) begin
            if (!found) begin
                tick();
                if (ld_tx_data != '0) begin
                    found = 1'b1;
                    ld    = ld_tx_data;
                    d     = tx_data;
                    at    = cyc;
                end
            end
        end
    endtask

    function automatic logic [WIDTH-1:0] pkt(input int i);
        return {32'hC0DE_0000 + 32'(i), 32'h1234_5678 ^ 32'(i)};
    endfunction

    initial begin
        logic [NUMPORTS-1:0] ld;
        logic [WIDTH-1:0]    d;
        int                  at;
        int                  prev_at;
        int                  n_rd;
        int                  n_ld;
        logic [NUMPORTS-1:0] exp_busy [0:2];

        reset_n     = 1'b0;
        enable_miso = 4'b0001;
        tx_busy     = 4'b0000;
        fifo_data   = '0;
        push(64'hDEAD_BEEF_0123_4567);

        // Reset held 3 cycles with a non-empty FIFO.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_no_rd", 64'(fifo_rd_en), 64'd0);
        end
        check("rst_ld", 64'(ld_tx_data), 64'd0);
        check("rst_tx_data", tx_data, 64'd0);
        check("rst_count", 64'(tx_count), 64'd0);

        // Single packet to port 0: rd_en at n+1, load at n+3, count after.
        reset_n = 1'b1;
        tick();
        check("single_rd_n1", 64'(fifo_rd_en), 64'd1);
        check("single_ld_n1", 64'(ld_tx_data), 64'd0);
        tick();
        check("single_rd_n2", 64'(fifo_rd_en), 64'd0);
        tick();
        check("single_ld_n3", 64'(ld_tx_data), 64'b0001);
        check("single_data_n3", tx_data, 64'hDEAD_BEEF_0123_4567);
        tick();
        check("single_ld_n4", 64'(ld_tx_data), 64'd0);
        check("single_data_hold", tx_data, 64'hDEAD_BEEF_0123_4567);
        check("single_count", 64'(tx_count), 64'd1);

        // Round-robin over all ports, one load every 4 cycles.
        do_reset();
        enable_miso = 4'b1111;
        for (int i = 0; i < 8; i++) push(pkt(i));
        prev_at = 0;
        for (int i = 0; i < 8; i++) begin
            wait_load(12, ld, d, at);
            check($sformatf("rr_port%0d", i), 64'(ld), 64'(4'b0001 << (i % 4)));
            check($sformatf("rr_data%0d", i), d, pkt(i));
            if (i > 0) check($sformatf("rr_gap%0d", i), 64'(at - prev_at), 64'd4);
            prev_at = at;
        end
        tick();
        check("rr_count", 64'(tx_count), 64'd8);

        // Busy ports 1 and 2 are skipped.
        do_reset();
        tx_busy     = 4'b0110;
        exp_busy[0] = 4'b0001;
        exp_busy[1] = 4'b1000;
        exp_busy[2] = 4'b0001;
        for (int i = 0; i < 3; i++) push(pkt(100 + i));
        for (int i = 0; i < 3; i++) begin
            wait_load(12, ld, d, at);
            check($sformatf("busy_port%0d", i), 64'(ld), 64'(exp_busy[i]));
            check($sformatf("busy_data%0d", i), d, pkt(100 + i));
        end
        tick();
        tx_busy = 4'b0000;

        // Zero mask never pops; enabling port 2 then loads within 4 cycles.
        do_reset();
        enable_miso = 4'b0000;
        push(pkt(200));
        n_rd = 0;
        n_ld = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (fifo_rd_en === 1'b1) n_rd++;
            if (ld_tx_data != '0) n_ld++;
        end
        check("mask0_no_rd", 64'(n_rd), 64'd0);
        check("mask0_no_ld", 64'(n_ld), 64'd0);
        check("mask0_fifo_kept", 64'(fifo_empty), 64'd0);
        enable_miso = 4'b0100;
        wait_load(4, ld, d, at);
        check("mask_en2_port", 64'(ld), 64'b0100);
        check("mask_en2_data", d, pkt(200));
        tick();

        // Reset asserted in CAPTURE: no load, outputs cleared, port 0 served next.
        do_reset();
        enable_miso = 4'b1111;
        push(pkt(300));
        tick();
        check("midrst_fetch", 64'(fifo_rd_en), 64'd1);
        tick();
        reset_n = 1'b0;
        tick();
        check("midrst_no_ld", 64'(ld_tx_data), 64'd0);
        check("midrst_rd", 64'(fifo_rd_en), 64'd0);
        check("midrst_data", tx_data, 64'd0);
        check("midrst_count", 64'(tx_count), 64'd0);
        reset_n = 1'b1;
        push(pkt(301));
        tick();
        check("midrst_idle_rd", 64'(fifo_rd_en), 64'd1);
        wait_load(6, ld, d, at);
        check("midrst_next_port", 64'(ld), 64'b0001);
        check("midrst_next_data", d, pkt(301));
        tick();
        check("midrst_next_count", 64'(tx_count), 64'd1);

        check("strobe_shape", 64'(n_proto), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
